// File: rtl/fighter_jump_sprite_pkg.sv
// Shared types and constants for the fighter jump-sprite stage.
// FIGHTER_MIRROR_EN (optional macro) enables horizontal mirroring elsewhere.
package fighter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASCEND  = 2'd1,
    DESCEND = 2'd2,
    LAND    = 2'd3
  } jump_state_t;

  localparam int SPRITE_DIM = 64;
  localparam int SPRITE_AW  = 12;
  localparam int H_LAST     = 639;
  localparam int V_LAST     = 479;

  // 5-bit add that clamps at 31 instead of wrapping
  function automatic logic [4:0] sat_add5(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    sat_add5 = sum[5] ? 5'd31 : sum[4:0];
  endfunction

endpackage

// File: rtl/fighter_jump_sprite_if.sv
// Pixel-scan / sprite-output bundle between the scan generator, this stage
// and the ROM/compositor. facing_left exists only with FIGHTER_MIRROR_EN.
interface fighter_jump_sprite_if;
  import fighter_pkg::*;

  logic [9:0]           DrawX;
  logic [9:0]           DrawY;
  logic                 blank;
  logic                 jump_req;
  logic [9:0]           fighter_x;
  logic [SPRITE_AW-1:0] rom_address;
  logic                 sprite_hit;
  logic                 jumping;
`ifdef FIGHTER_MIRROR_EN
  logic                 facing_left;

  modport master (output DrawX, DrawY, blank, jump_req, fighter_x, facing_left,
                  input  rom_address, sprite_hit, jumping);
  modport slave  (input  DrawX, DrawY, blank, jump_req, fighter_x, facing_left,
                  output rom_address, sprite_hit, jumping);
`else
  modport master (output DrawX, DrawY, blank, jump_req, fighter_x,
                  input  rom_address, sprite_hit, jumping);
  modport slave  (input  DrawX, DrawY, blank, jump_req, fighter_x,
                  output rom_address, sprite_hit, jumping);
`endif
endinterface

// File: rtl/fighter_jump_sprite_tick.sv
// Once-per-frame pulse: fires the cycle after the last visible pixel is first seen.
module frame_tick_gen
  import fighter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  output logic       tick_o
);

  logic last_s;
  logic last_q;
  logic tick_q;

  assign last_s = (draw_x_i == 10'(H_LAST)) && (draw_y_i == 10'(V_LAST));

  // Rising-edge detect on the last-pixel condition, registered pulse out
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      last_q <= last_s;
      tick_q <= last_s && !last_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/fighter_jump_sprite.sv
// Fighter jump sprite: frame-rate jump FSM plus zero-latency 64x64 ROM
// addressing and hit flag. Optional macro FIGHTER_MIRROR_EN adds facing_left.
module fighter_jump_sprite
  import fighter_pkg::*;
#(
  parameter int Y_GROUND    = 400,
  parameter int JUMP_VEL    = 12,
  parameter int GRAVITY     = 1,
  parameter int LAND_FRAMES = 4
) (
  input  logic                 vga_clk,
  input  logic                 Reset,
  fighter_jump_sprite_if.slave bus
);

  localparam logic [9:0] Y_GROUND_C = 10'(Y_GROUND);
  localparam logic [4:0] VEL_C      = 5'(JUMP_VEL);
  localparam logic [4:0] GRAV_C     = 5'(GRAVITY);
  localparam logic [3:0] LAND_C     = 4'(LAND_FRAMES - 1);

  jump_state_t state_q, state_d;
  logic [9:0]  pos_x_q;
  logic [9:0]  pos_y_q, pos_y_d;
  logic [4:0]  vel_q, vel_d;
  logic [3:0]  land_q, land_d;
  logic        jumping_q;
  logic        tick_s;
  logic [10:0] descend_sum_s;
  logic [10:0] x_end_s, y_end_s;
  logic [5:0]  dx_s, dy_s, col_s;
  logic        in_box_s;

  frame_tick_gen u_tick (
    .clk_i    (vga_clk),
    .rst_i    (Reset),
    .draw_x_i (bus.DrawX),
    .draw_y_i (bus.DrawY),
    .tick_o   (tick_s)
  );

  // 11-bit so the landing compare cannot wrap
  assign descend_sum_s = {1'b0, pos_y_q} + {6'd0, vel_q} + {6'd0, GRAV_C};

  // Jump FSM next state; only committed on frame tick
  always_comb begin
    state_d = state_q;
    pos_y_d = pos_y_q;
    vel_d   = vel_q;
    land_d  = land_q;
    case (state_q)
      IDLE: begin
        if (bus.jump_req) begin
          vel_d   = VEL_C;
          state_d = ASCEND;
        end else begin
          state_d = IDLE;
        end
      end
      ASCEND: begin
        pos_y_d = pos_y_q - {5'd0, vel_q};
        if (vel_q <= GRAV_C) begin
          vel_d   = 5'd0;
          state_d = DESCEND;
        end else begin
          vel_d = vel_q - GRAV_C;
        end
      end
      DESCEND: begin
        if (descend_sum_s >= {1'b0, Y_GROUND_C}) begin
          pos_y_d = Y_GROUND_C;
          vel_d   = 5'd0;
          land_d  = LAND_C;
          state_d = LAND;
        end else begin
          pos_y_d = descend_sum_s[9:0];
          vel_d   = sat_add5(vel_q, GRAV_C);
        end
      end
      LAND: begin
        if (land_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          land_d = land_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Motion state registers, updated only at the frame boundary
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pos_x_q   <= 10'd0;
      pos_y_q   <= Y_GROUND_C;
      vel_q     <= 5'd0;
      land_q    <= 4'd0;
      jumping_q <= 1'b0;
    end else if (tick_s) begin
      state_q   <= state_d;
      pos_x_q   <= bus.fighter_x;
      pos_y_q   <= pos_y_d;
      vel_q     <= vel_d;
      land_q    <= land_d;
      jumping_q <= (state_d != IDLE);
    end
  end

`ifdef FIGHTER_MIRROR_EN
  logic facing_q;

  // Facing direction latched with the rest of the frame state
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      facing_q <= 1'b0;
    end else if (tick_s) begin
      facing_q <= bus.facing_left;
    end
  end

  assign col_s = facing_q ? (6'd63 - dx_s) : dx_s;
`else
  assign col_s = dx_s;
`endif

  // Only the low six bits of the offsets reach the ROM
  assign dx_s     = bus.DrawX[5:0] - pos_x_q[5:0];
  assign dy_s     = bus.DrawY[5:0] - pos_y_q[5:0];
  assign x_end_s  = {1'b0, pos_x_q} + 11'(SPRITE_DIM);
  assign y_end_s  = {1'b0, pos_y_q} + 11'(SPRITE_DIM);
  assign in_box_s = (bus.DrawX >= pos_x_q) && ({1'b0, bus.DrawX} < x_end_s) &&
                    (bus.DrawY >= pos_y_q) && ({1'b0, bus.DrawY} < y_end_s);

  assign bus.rom_address = {dy_s, col_s};
  assign bus.sprite_hit  = in_box_s && bus.blank;
  assign bus.jumping     = jumping_q;

endmodule

// File: tb/tb_fighter_jump_sprite.sv
// Self-checking bench for fighter_jump_sprite: frame ticks are produced by
// parking the scan on the last visible pixel for one cycle; a per-frame
// trajectory model predicts the sprite box and jumping flag.
module tb_fighter_jump_sprite;

  localparam int Y_G = 400;
  localparam int JV  = 12;
  localparam int GR  = 1;
  localparam int LF  = 4;

  typedef struct {
    int y;
    bit j;
  } ent_t;

  logic vga_clk;
  logic Reset;
  bit   chk_en;
  int   n_chk;
  int   n_fail;

  // model state: current box origin and jumping flag, plus future frames
  int   m_x, m_y;
  bit   m_j;
  ent_t traj_q[$];

  fighter_jump_sprite_if bus();

  fighter_jump_sprite dut (
    .vga_clk (vga_clk),
    .Reset   (Reset),
    .bus     (bus)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Whole jump as a list of per-frame heights: rise, fall, then ground frames
  function automatic void build_jump();
    int y, v;
    ent_t e;
    y = Y_G;
    v = JV;
    forever begin
      y = y - v;
      e.y = y; e.j = 1'b1; traj_q.push_back(e);
      if (v <= GR) break;
      v = v - GR;
    end
    v = 0;
    forever begin
      if (y + v + GR >= Y_G) begin
        e.y = Y_G; e.j = 1'b1; traj_q.push_back(e);
        break;
      end
      y = y + v + GR;
      v = (v + GR > 31) ? 31 : v + GR;
      e.y = y; e.j = 1'b1; traj_q.push_back(e);
    end
    for (int i = 0; i < LF - 1; i++) begin
      e.y = Y_G; e.j = 1'b1; traj_q.push_back(e);
    end
    e.y = Y_G; e.j = 1'b0; traj_q.push_back(e);
  endfunction

  function automatic void model_step();
    ent_t e;
    m_x = int'(bus.fighter_x);
    if (traj_q.size() > 0) begin
      e = traj_q.pop_front();
      m_y = e.y;
      m_j = e.j;
    end else if (bus.jump_req) begin
      build_jump();
      m_y = Y_G;
      m_j = 1'b1;
    end else begin
      m_y = Y_G;
      m_j = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_x = 0;
    m_y = Y_G;
    m_j = 1'b0;
    traj_q.delete();
  endfunction

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge vga_clk) begin
    if (chk_en) begin
      int dx, dy;
      bit in_box;
      dx = int'(bus.DrawX) - m_x;
      dy = int'(bus.DrawY) - m_y;
      in_box = (dx >= 0) && (dx < 64) && (dy >= 0) && (dy < 64);
      check("hit", {31'd0, bus.sprite_hit}, {31'd0, in_box && (bus.blank === 1'b1)});
      check("jumping", {31'd0, bus.jumping}, {31'd0, m_j});
      if (in_box) check("addr", {20'd0, bus.rom_address}, 32'(dy * 64 + dx));
      else        check("addr_known", {31'd0, $isunknown(bus.rom_address)}, 32'd0);
    end
  end

  task automatic probe(input int x, input int y, input logic b);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    bus.blank = b;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic probe_lit(input string name, input int x, input int y, input logic b,
                           input logic exp_hit, input int exp_addr);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    bus.blank = b;
    #2;
    check({name, "_hit"}, {31'd0, bus.sprite_hit}, {31'd0, exp_hit});
    if (exp_hit) check({name, "_addr"}, {20'd0, bus.rom_address}, 32'(exp_addr));
    @(posedge vga_clk);
    #1;
  endtask

  task automatic tick();
    bus.DrawX = 10'd639;
    bus.DrawY = 10'd479;
    bus.blank = 1'b0;
    @(posedge vga_clk);
    #1;
    bus.DrawX = 10'd0;
    bus.DrawY = 10'd0;
    @(posedge vga_clk);
    model_step();
    #1;
  endtask

  task automatic run_frame();
    tick();
    probe(m_x, m_y, 1'b1);
    probe(m_x + 63, m_y + 63, 1'b1);
    probe(m_x, m_y - 1, 1'b1);
    probe(m_x + 64, m_y, 1'b1);
    probe(m_x + 5, m_y + 5, 1'b0);
  endtask

  int asc_lit [12] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322};

  initial begin
    n_chk = 0;
    n_fail = 0;
    chk_en = 1'b0;
    Reset = 1'b1;
    bus.DrawX = 10'd0;
    bus.DrawY = 10'd0;
    bus.blank = 1'b0;
    bus.jump_req = 1'b0;
    bus.fighter_x = 10'd100;
`ifdef FIGHTER_MIRROR_EN
    bus.facing_left = 1'b0;
`endif
    model_reset();
    #1;
    chk_en = 1'b1;
    @(posedge vga_clk); #1;
    @(posedge vga_clk); #1;
    probe_lit("reset_pix", 0, 400, 1'b1, 1'b1, 0);
    check("reset_jumping", {31'd0, bus.jumping}, 32'd0);
    Reset = 1'b0;
    @(posedge vga_clk); #1;

    // idle frames at ground
    for (int i = 0; i < 3; i++) run_frame();
    check("idle_jumping", {31'd0, bus.jumping}, 32'd0);
    probe_lit("tl", 100, 400, 1'b1, 1'b1, 0);
    probe_lit("br", 163, 463, 1'b1, 1'b1, 4095);
    probe_lit("right_out", 164, 400, 1'b1, 1'b0, 0);
    probe_lit("blank_off", 120, 420, 1'b0, 1'b0, 0);

    // box holds until the next frame boundary
    bus.fighter_x = 10'd300;
    probe(100, 200, 1'b1);
    probe_lit("midframe_old", 100, 400, 1'b1, 1'b1, 0);
    tick();
    probe_lit("moved_new", 300, 400, 1'b1, 1'b1, 0);
    probe_lit("moved_old", 100, 400, 1'b1, 1'b0, 0);
    bus.fighter_x = 10'd100;
    run_frame();

    // single pulsed jump
    bus.jump_req = 1'b1;
    run_frame();
    bus.jump_req = 1'b0;
    check("traj_len", 32'(traj_q.size()), 32'd28);
    for (int i = 0; i < 12; i++) check("traj_asc", 32'(traj_q[i].y), 32'(asc_lit[i]));
    check("traj_d7", 32'(traj_q[18].y), 32'd350);
    check("traj_land", 32'(traj_q[23].y), 32'd400);
    for (int i = 0; i < 12; i++) run_frame();
    probe_lit("apex", 100, 322, 1'b1, 1'b1, 0);
    probe_lit("apex_above", 100, 321, 1'b1, 1'b0, 0);
    for (int i = 0; i < 16; i++) run_frame();
    check("after_land_jumping", {31'd0, bus.jumping}, 32'd0);
    probe_lit("ground_back", 100, 400, 1'b1, 1'b1, 0);

    // held request: back-to-back jumps
    bus.jump_req = 1'b1;
    run_frame();
    check("held_start", {31'd0, bus.jumping}, 32'd1);
    for (int i = 0; i < 28; i++) run_frame();
    check("held_idle_frame", {31'd0, bus.jumping}, 32'd0);
    run_frame();
    check("held_restart", {31'd0, bus.jumping}, 32'd1);
    bus.jump_req = 1'b0;
    for (int i = 0; i < 19; i++) run_frame();
    probe_lit("desc350", 100, 350, 1'b1, 1'b1, 0);
    probe_lit("desc349", 100, 349, 1'b1, 1'b0, 0);

    // asynchronous reset mid-descent, checked before any clock edge
    bus.DrawX = 10'd0;
    bus.DrawY = 10'd400;
    bus.blank = 1'b1;
    #1;
    check("pre_reset_hit", {31'd0, bus.sprite_hit}, 32'd0);
    Reset = 1'b1;
    model_reset();
    #1;
    check("async_hit", {31'd0, bus.sprite_hit}, 32'd1);
    check("async_addr", {20'd0, bus.rom_address}, 32'd0);
    check("async_jumping", {31'd0, bus.jumping}, 32'd0);
    @(posedge vga_clk); #1;
    @(posedge vga_clk); #1;
    Reset = 1'b0;
    @(posedge vga_clk); #1;

    // first frame after reset behaves as from idle
    bus.jump_req = 1'b1;
    run_frame();
    bus.jump_req = 1'b0;
    check("post_reset_jump", {31'd0, bus.jumping}, 32'd1);
    run_frame();
    probe_lit("post_reset_y", 100, 388, 1'b1, 1'b1, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
